// File: rtl/uart_tx_framer_if.sv
// Word-in / serial-out signal bundle for the UART transmit framer.
// The source side uses master and the framer uses slave.
interface uart_tx_framer_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] P_DATA;
    logic             data_valid;
    logic             ready;
    logic             TX_OUT;
    logic             busy;
    logic             tx_done;

    modport master (
        output P_DATA, data_valid,
        input  ready, TX_OUT, busy, tx_done
    );

    modport slave (
        input  P_DATA, data_valid,
        output ready, TX_OUT, busy, tx_done
    );
endinterface

// File: rtl/uart_tx_framer.sv
// UART transmit framer: a one-word holding buffer feeds a start/data/stop serialiser.
// Frames run back-to-back with no idle gap whenever the buffer is already full.
module uart_tx_framer #(
    parameter int WIDTH        = 32,
    parameter int CLKS_PER_BIT = 1
) (
    input  logic              clk,
    input  logic              rst,
    uart_tx_framer_if.slave   bus
);
    localparam int CW = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [5:0]    DATA_LAST = 6'(WIDTH - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] DATA  = 2'd2;
    localparam logic [1:0] STOP  = 2'd3;

    logic [1:0]       state_reg, state_next;
    logic [WIDTH-1:0] hold_data_reg;
    logic             hold_full_reg, hold_full_next;
    logic [WIDTH-1:0] shift_reg, shift_next;
    logic [CW-1:0]    bit_cnt_reg, bit_cnt_next;
    logic [5:0]       data_cnt_reg, data_cnt_next;
    logic             tx_reg;
    logic             tx_done_reg;
    logic             accept;
    logic             load;
    logic             bit_end;

    assign accept  = bus.data_valid && !hold_full_reg;
    assign bit_end = (bit_cnt_reg == BIT_LAST);

    always_comb begin
        state_next    = state_reg;
        shift_next    = shift_reg;
        bit_cnt_next  = bit_cnt_reg;
        data_cnt_next = data_cnt_reg;
        load          = 1'b0;
        case (state_reg)
            IDLE: begin
                if (hold_full_reg) begin
                    load          = 1'b1;
                    state_next    = START;
                    bit_cnt_next  = '0;
                    data_cnt_next = '0;
                end
            end
            START: begin
                if (bit_end) begin
                    state_next   = DATA;
                    bit_cnt_next = '0;
                end else begin
                    bit_cnt_next = bit_cnt_reg + 1'b1;
                end
            end
            DATA: begin
                if (bit_end) begin
                    bit_cnt_next = '0;
                    shift_next   = shift_reg >> 1;
                    if (data_cnt_reg == DATA_LAST) begin
                        state_next = STOP;
                    end else begin
                        data_cnt_next = data_cnt_reg + 6'd1;
                    end
                end else begin
                    bit_cnt_next = bit_cnt_reg + 1'b1;
                end
            end
            default: begin
                if (bit_end) begin
                    bit_cnt_next = '0;
                    if (hold_full_reg) begin
                        // Chain straight into the next start bit.
                        load          = 1'b1;
                        state_next    = START;
                        data_cnt_next = '0;
                    end else begin
                        state_next = IDLE;
                    end
                end else begin
                    bit_cnt_next = bit_cnt_reg + 1'b1;
                end
            end
        endcase
        if (load) begin
            shift_next = hold_data_reg;
        end
    end

    // A load and an accept on the same edge leave the buffer full with the new word.
    assign hold_full_next = (hold_full_reg && !load) || accept;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= IDLE;
            hold_data_reg <= '0;
            hold_full_reg <= 1'b0;
            shift_reg     <= '0;
            bit_cnt_reg   <= '0;
            data_cnt_reg  <= '0;
            tx_reg        <= 1'b1;
            tx_done_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            hold_full_reg <= hold_full_next;
            shift_reg     <= shift_next;
            bit_cnt_reg   <= bit_cnt_next;
            data_cnt_reg  <= data_cnt_next;
            if (accept) begin
                hold_data_reg <= bus.P_DATA;
            end
            // Line and done flag are registered from the current state, so they trail it by one cycle.
            case (state_reg)
                START:   tx_reg <= 1'b0;
                DATA:    tx_reg <= shift_reg[0];
                default: tx_reg <= 1'b1;
            endcase
            tx_done_reg <= (state_reg == STOP) && bit_end;
        end
    end

    assign bus.ready   = !hold_full_reg;
    assign bus.busy    = (state_reg != IDLE) || hold_full_reg;
    assign bus.TX_OUT  = tx_reg;
    assign bus.tx_done = tx_done_reg;
endmodule

// File: tb/tb_uart_tx_framer.sv
// Scoreboard bench: senders queue expected words, a negedge monitor decodes each serial frame
// from two framer instances (1 and 4 clocks per bit) and compares it against the queue.
module tb_uart_tx_framer;
    logic clk;
    logic rst;

    uart_tx_framer_if #(.WIDTH(32)) bus0 ();
    uart_tx_framer_if #(.WIDTH(32)) bus1 ();

    uart_tx_framer #(.WIDTH(32), .CLKS_PER_BIT(1)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
    uart_tx_framer #(.WIDTH(32), .CLKS_PER_BIT(4)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] q0[$];
    logic [31:0] q1[$];

    int          cpb [2] = '{1, 4};
    bit          m_act [2];
    int          m_cyc [2];
    logic [31:0] m_word [2];
    int          ncyc = 0;
    int          done_prev0 = 0;
    int          done_last0 = 0;

    wire [1:0] txv   = {bus1.TX_OUT, bus0.TX_OUT};
    wire [1:0] donev = {bus1.tx_done, bus0.tx_done};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s got %h want %h", name, got, want);
        end
    endtask

    // Frame decoder / scoreboard for both instances.
    always @(negedge clk) begin
        ncyc++;
        if (!rst) begin
            m_act[0] = 1'b0;
            m_act[1] = 1'b0;
            q0.delete();
            q1.delete();
        end else begin
            for (int i = 0; i < 2; i++) begin
                logic        t;
                logic        d;
                logic [31:0] w;
                int          c;
                int          b;
                bit          last;
                t = txv[i];
                d = donev[i];
                if (!m_act[i]) begin
                    if (d) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL done_outside_frame inst%0d got 1 want 0", i);
                    end
                    if (!t) begin
                        m_act[i] = 1'b1;
                        m_cyc[i] = 0;
                    end
                end
                if (m_act[i]) begin
                    c    = cpb[i];
                    b    = m_cyc[i] / c;
                    last = (m_cyc[i] == 34 * c - 1);
                    if (last) begin
                        check($sformatf("done_final_inst%0d", i), {31'd0, d}, 32'd1);
                    end else if (d) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL done_early inst%0d cycle %0d got 1 want 0", i, m_cyc[i]);
                    end
                    if ((m_cyc[i] % c) == c / 2) begin
                        if (b == 0) begin
                            check($sformatf("start_bit_inst%0d", i), {31'd0, t}, 32'd0);
                        end else if (b <= 32) begin
                            m_word[i][b-1] = t;
                        end else begin
                            check($sformatf("stop_bit_inst%0d", i), {31'd0, t}, 32'd1);
                        end
                    end
                    if (last) begin
                        m_act[i] = 1'b0;
                        if ((i == 0 && q0.size() == 0) || (i == 1 && q1.size() == 0)) begin
                            vectors++;
                            miscompares++;
                            $display("FAIL unexpected_frame inst%0d got %h want none", i, m_word[i]);
                        end else begin
                            w = (i == 0) ? q0.pop_front() : q1.pop_front();
                            $display("frame inst%0d rx %h exp %h", i, m_word[i], w);
                            check($sformatf("frame_word_inst%0d", i), m_word[i], w);
                        end
                        if (i == 0) begin
                            done_prev0 = done_last0;
                            done_last0 = ncyc;
                        end
                    end else begin
                        m_cyc[i]++;
                    end
                end
            end
        end
    end

    // All senders start and end one time unit after a rising edge.
    task automatic send0(input logic [31:0] w);
        int n;
        bus0.P_DATA     = w;
        bus0.data_valid = 1'b1;
        n = 0;
        while (!bus0.ready && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        if (!bus0.ready) check("send0_ready_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        q0.push_back(w);
        bus0.data_valid = 1'b0;
    endtask

    task automatic send1(input logic [31:0] w);
        int n;
        bus1.P_DATA     = w;
        bus1.data_valid = 1'b1;
        n = 0;
        while (!bus1.ready && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        if (!bus1.ready) check("send1_ready_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        q1.push_back(w);
        bus1.data_valid = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int n = 0; n < 3000 && !ok; n++) begin
            if (q0.size() == 0 && q1.size() == 0 && !bus0.busy && !bus1.busy
                && !m_act[0] && !m_act[1]) begin
                ok = 1'b1;
            end else begin
                @(posedge clk); #1;
            end
        end
        check("wait_idle_timeout", {31'd0, ok}, 32'd1);
    endtask

    initial begin
        rst             = 1'b0;
        bus0.P_DATA     = '0;
        bus0.data_valid = 1'b0;
        bus1.P_DATA     = '0;
        bus1.data_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_tx0",    {31'd0, bus0.TX_OUT},  32'd1);
        check("rst_ready0", {31'd0, bus0.ready},   32'd1);
        check("rst_busy0",  {31'd0, bus0.busy},    32'd0);
        check("rst_done0",  {31'd0, bus0.tx_done}, 32'd0);
        check("rst_tx1",    {31'd0, bus1.TX_OUT},  32'd1);
        check("rst_ready1", {31'd0, bus1.ready},   32'd1);
        check("rst_busy1",  {31'd0, bus1.busy},    32'd0);
        check("rst_done1",  {31'd0, bus1.tx_done}, 32'd0);
        rst = 1'b1;

        // First word after reset; line goes low two edges after the accepting edge.
        bus0.P_DATA     = 32'hA5A5_0F01;
        bus0.data_valid = 1'b1;
        q0.push_back(32'hA5A5_0F01);
        @(posedge clk); #1;
        bus0.data_valid = 1'b0;
        check("busy_after_accept", {31'd0, bus0.busy}, 32'd1);
        @(negedge clk);
        check("lat_edge_k",  {31'd0, bus0.TX_OUT}, 32'd1);
        @(negedge clk);
        check("lat_edge_k1", {31'd0, bus0.TX_OUT}, 32'd1);
        @(negedge clk);
        check("lat_edge_k2", {31'd0, bus0.TX_OUT}, 32'd0);
        @(posedge clk); #1;
        wait_idle();

        // Back-to-back frames.
        send0(32'h0000_0000);
        send0(32'hFFFF_FFFF);
        wait_idle();
        check("b2b_done_spacing", 32'(done_last0 - done_prev0), 32'd34);

        // Four clocks per bit.
        send1(32'h0000_0001);
        wait_idle();

        // Third word waits while the buffer is full.
        send0(32'h1234_5678);
        send0(32'hCAFE_F00D);
        bus0.P_DATA     = 32'h0BAD_BEEF;
        bus0.data_valid = 1'b1;
        check("ready_low_when_full", {31'd0, bus0.ready}, 32'd0);
        send0(32'h0BAD_BEEF);
        wait_idle();

        // Valid held high while data changes every cycle.
        bus0.data_valid = 1'b1;
        for (int n = 0; n < 80; n++) begin
            bus0.P_DATA = 32'h5A00_0000 | 32'(n * 32'h0001_0203);
            if (bus0.ready) q0.push_back(bus0.P_DATA);
            @(posedge clk); #1;
        end
        bus0.data_valid = 1'b0;
        wait_idle();

        // Asynchronous reset mid-frame with a second word buffered.
        send0(32'h0F0F_0F0F);
        send0(32'h3333_3333);
        repeat (9) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        check("abort_tx",    {31'd0, bus0.TX_OUT},  32'd1);
        check("abort_busy",  {31'd0, bus0.busy},    32'd0);
        check("abort_ready", {31'd0, bus0.ready},   32'd1);
        check("abort_done",  {31'd0, bus0.tx_done}, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        send0(32'h8000_0001);
        wait_idle();

        check("q0_drained", 32'(q0.size()), 32'd0);
        check("q1_drained", 32'(q1.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/uart_tx_framer.md
UART_TX_FRAMER -- requirements
Module: uart_tx_framer

Interface
REQ-001 SHALL have parameter WIDTH, default 32: number of data bits per frame, 1..63.
REQ-002 SHALL have parameter CLKS_PER_BIT, default 1: clock cycles per serial bit time, >=1.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset: asserted when 0, independent of clk.
REQ-005 SHALL have port P_DATA  input  WIDTH  parallel word to transmit.
REQ-006 SHALL have port data_valid  input  1  P_DATA holds a word offered for transmission.
REQ-007 SHALL have port ready  output  1  the block can accept a word this cycle.
REQ-008 SHALL have port TX_OUT  output  1  registered serial line; idle level 1.
REQ-009 SHALL have port busy  output  1  a frame is in progress or a word is buffered.
REQ-010 SHALL have port tx_done  output  1  one-cycle pulse at the end of each frame's stop bit.

Function
REQ-011 SHALL contain a 1-entry holding register (hold_data, hold_full) and a WIDTH-bit shift register.
REQ-012 SHALL drive ready = !hold_full combinationally.
REQ-013 SHALL accept a word on a rising edge where data_valid && ready: hold_data<=P_DATA, hold_full<=1.
REQ-014 SHALL ignore data_valid while ready is 0; the source keeps P_DATA stable until accepted.
REQ-015 SHALL implement an FSM with states IDLE, START, DATA, STOP.
REQ-016 IDLE: TX_OUT=1; if hold_full, next edge loads the shifter from hold_data, clears hold_full, enters START.
REQ-017 START: TX_OUT=0 for CLKS_PER_BIT cycles, then DATA.
REQ-018 DATA: TX_OUT=shifter[0] for CLKS_PER_BIT cycles per bit, then shift right; LSB first; after WIDTH bits, enter STOP.
REQ-019 STOP: TX_OUT=1 for CLKS_PER_BIT cycles; on the final cycle, go to START if hold_full, loading the shifter and clearing hold_full (back-to-back, no idle gap); otherwise go to IDLE.
REQ-020 SHALL count bit-time cycles 0..CLKS_PER_BIT-1 with a $clog2(CLKS_PER_BIT+1)-bit counter; reset it on every bit boundary.
REQ-021 SHALL count data bits 0..WIDTH-1 with a 6-bit counter; clear it on entry to START.
REQ-022 SHALL make the frame length exactly (WIDTH+2)*CLKS_PER_BIT cycles: 1 start bit, WIDTH data bits, 1 stop bit.
REQ-023 Latency: word accepted at edge k (IDLE, empty buffer) -> TX_OUT=0 from edge k+2.
REQ-024 SHALL pulse tx_done high for exactly the final cycle of every stop bit, including back-to-back frames.
REQ-025 SHALL drive busy = (state != IDLE) || hold_full.
REQ-026 Simultaneous load and accept, same edge: hold_full stays 1 and holds the new word; the shifter holds the old buffered word.
REQ-027 SHALL NOT let data_valid or P_DATA changes mid-frame affect the frame in flight.

Reset
REQ-028 While rst=0: TX_OUT=1, ready=1, busy=0, tx_done=0, state=IDLE, hold_full=0, all counters 0.
REQ-029 rst asserted mid-frame SHALL abort it immediately, with no clk edge needed, and discard any buffered word.
REQ-030 After rst deasserts, the first word SHALL be accepted on the first edge with data_valid=1.

Verification
REQ-031 WIDTH=32, CPB=1, send 0xA5A50F01 -> TX_OUT: 0, then 1,0,0,0,0,0,0,0,1,1,1,1,0,0,0,0,1,0,1,0,0,1,0,1,1,0,1,0,0,1,0,1, then 1; 34 cycles; tx_done once.
REQ-032 Two words offered back-to-back (0x00000000, 0xFFFFFFFF) -> 68 contiguous cycles, second start bit right after first stop bit, two tx_done pulses 34 cycles apart.
REQ-033 Third word held valid while buffer full -> ready=0, not captured until the shifter loads; words emerge in offer order with none lost or duplicated.
REQ-034 CPB=4, send 0x00000001 -> each bit 4 cycles (start low 4, bit0 high 4, 31x low 4, stop high 4); frame 136 cycles.
REQ-035 rst=0 at cycle 10 of a frame -> TX_OUT=1, busy=0, ready=1 immediately, no tx_done; next word transmits as a complete fresh frame.
REQ-036 data_valid held high continuously with changing P_DATA -> only the values present on accepting edges are transmitted.
